// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode enum and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    INC = 3'b010,
    DEC = 3'b011,
    AND = 3'b100,
    OR  = 3'b101,
    XOR = 3'b110,
    NOT = 3'b111
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (a, b, op) -> (result, flags).
// Optional unsigned saturation of ADD/SUB/INC/DEC under `ALU_SAT_EN.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] bop;
  logic [WIDTH:0]   sum;
  logic             is_arith;
  logic             is_sub;
  logic             ovf;

  always_comb begin
    is_arith = (op == ADD) || (op == SUB) || (op == INC) || (op == DEC);
    is_sub   = (op == SUB) || (op == DEC);
    bop      = ((op == INC) || (op == DEC)) ? ONE : b;
    sum      = is_sub ? ({1'b0, a} - {1'b0, bop}) : ({1'b0, a} + {1'b0, bop});
    // Add overflows on like signs, subtract on unlike signs; both flip the result sign.
    ovf      = is_arith && ((a[WIDTH-1] ^ bop[WIDTH-1]) == is_sub)
                        && (sum[WIDTH-1] != a[WIDTH-1]);

    case (op)
      AND:     result = a & b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      NOT:     result = ~b;
`ifdef ALU_SAT_EN
      default: result = !sum[WIDTH] ? sum[WIDTH-1:0] : (is_sub ? '0 : '1);
`else
      default: result = sum[WIDTH-1:0];
`endif
    endcase

    flags         = '0;
    flags[FLAG_C] = is_arith & sum[WIDTH];
    flags[FLAG_V] = ovf;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: operand register -> alu_core -> result register.
// Build with ALU_SAT_EN defined for saturating arithmetic.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  alu_op_e          op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  localparam int STAGES = 2;

  logic [STAGES:1]  vld_pipe;
  logic [WIDTH-1:0] a_q, b_q, res;
  alu_op_e          op_q;
  logic [3:0]       res_flags;
  logic             s2_load, s1_load;

  // en gates both stages, so a low en freezes everything and blocks any transfer.
  assign s2_load   = en && (!vld_pipe[2] || out_ready);
  assign s1_load   = en && (!vld_pipe[1] || s2_load);
  assign in_ready  = s1_load;
  assign out_valid = vld_pipe[2];

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (res),
    .flags  (res_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      out      <= '0;
      flags    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= ADD;
    end else begin
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out   <= res;
          flags <= res_flags;
        end
      end
      if (s1_load) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          a_q  <= in1;
          b_q  <= in2;
          op_q <= op;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): directed vectors, backpressure, enable stall, mid-flight reset.
`timescale 1ns/1ps
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 8;
`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] o;
    logic [3:0]   f;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  alu_op_e      op = ADD;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic [3:0]   flags;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input alu_op_e o,
                      input logic [W-1:0] eo, input logic [3:0] ef);
    int t = 0;
    in1 = a; in2 = b; op = o; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    else q.push_back('{o: eo, f: ef});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    while ((q.size() != 0 || out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops on every transfer, and checks stability across stalled cycles.
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_out = '0;
  logic [3:0]   prev_flags = '0;
  exp_t         mon_e;
  initial forever begin
    @(negedge clk);
    if (rst) prev_hold = 1'b0;
    else begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_out", out, prev_out);
        check("hold_flags", flags, prev_flags);
      end
      if (out_valid && out_ready && en) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h with nothing expected", out);
        end else begin
          mon_e = q.pop_front();
          check("out", out, mon_e.o);
          check("flags", flags, mon_e.f);
        end
      end
      prev_hold  = out_valid && !(out_ready && en);
      prev_out   = out;
      prev_flags = flags;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_flags", flags, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed vectors; flags = {C,V,N,Z}
    send(8'h7F, 8'h01, ADD, 8'h80, 4'b0110);
    send(8'h00, 8'h01, SUB, SAT ? 8'h00 : 8'hFF, SAT ? 4'b1001 : 4'b1010);
    send(8'hFF, 8'h00, INC, SAT ? 8'hFF : 8'h00, SAT ? 4'b1010 : 4'b1001);
    send(8'h00, 8'h0F, NOT, 8'hF0, 4'b0010);
    send(8'hF0, 8'h3C, AND, 8'h30, 4'b0000);
    send(8'h0F, 8'h30, OR,  8'h3F, 4'b0000);
    send(8'hFF, 8'hFF, XOR, 8'h00, 4'b0001);
    send(8'h00, 8'h00, DEC, SAT ? 8'h00 : 8'hFF, SAT ? 4'b1001 : 4'b1010);
    send(8'hFF, 8'h01, ADD, SAT ? 8'hFF : 8'h00, SAT ? 4'b1010 : 4'b1001);
    send(8'h80, 8'h01, SUB, 8'h7F, 4'b0100);
    send(8'h80, 8'h00, DEC, 8'h7F, 4'b0100);
    send(8'h40, 8'h30, ADD, 8'h70, 4'b0000);
    drain();

    // Backpressure: sink stalls for 3 cycles while 4 beats stream in
    fork
      begin
        send(8'h01, 8'h01, ADD, 8'h02, 4'b0000);
        send(8'h02, 8'h02, ADD, 8'h04, 4'b0000);
        send(8'h09, 8'h03, SUB, 8'h06, 4'b0000);
        send(8'hAA, 8'h55, XOR, 8'hFF, 4'b0010);
      end
      begin
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
      end
    join
    drain();

    // Enable stall with one beat in each stage
    fork
      begin
        send(8'h01, 8'h02, OR,  8'h03, 4'b0000);
        send(8'hFF, 8'h81, AND, 8'h81, 4'b0010);
        send(8'h10, 8'h00, INC, 8'h11, 4'b0000);
      end
      begin
        repeat (2) @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        check("en_in_ready", in_ready, 0);
        check("en_out_valid", out_valid, 1);
        repeat (2) @(posedge clk);
        #1 en = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight: neither may ever appear
    out_ready = 1'b0;
    send(8'h11, 8'h11, ADD, 8'h22, 4'b0000);
    send(8'h01, 8'h02, ADD, 8'h03, 4'b0000);
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_flags", flags, 0);
    check("midrst_out", out, 0);
    repeat (4) @(posedge clk);
    #1;
    send(8'h0F, 8'hF0, XOR, 8'hFF, 4'b0010);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
